// File: rtl/uart_frame_ctrl_if.sv
// UART byte stream and crypto-core handshake bundle for uart_frame_ctrl.
// master: the frame controller; slave: the UART/core side.
interface uart_frame_ctrl_if;
  logic [7:0]   uart_rxdata;
  logic         uart_rxrdy;
  logic         uart_rxerr;
  logic         uart_txrdy;
  logic         uart_txstart;
  logic [7:0]   uart_txdata;
  logic [127:0] core_din;
  logic         core_start;
  logic         core_done;
  logic [127:0] core_dout;

  modport master (
    input  uart_rxdata, uart_rxrdy, uart_rxerr, uart_txrdy, core_done, core_dout,
    output uart_txstart, uart_txdata, core_din, core_start
  );

  modport slave (
    output uart_rxdata, uart_rxrdy, uart_rxerr, uart_txrdy, core_done, core_dout,
    input  uart_txstart, uart_txdata, core_din, core_start
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Collects a 16-byte UART frame, runs it through the crypto core, streams the result back.
// Optional FRAME_CHECKSUM_EN: trailing XOR checksum byte on both receive and transmit.
module uart_frame_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FRAME_BYTES    = 16
) (
  input  logic          clkin,
  input  logic          rstin,
  uart_frame_ctrl_if.master bus,
  output logic          busy,
  output logic          err
);
  localparam int W  = FRAME_BYTES * 8;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef FRAME_CHECKSUM_EN
  localparam int NBYTES = FRAME_BYTES + 1;
`else
  localparam int NBYTES = FRAME_BYTES;
`endif

  typedef enum logic [2:0] {RX, CHK, START, WAIT_CORE, TX_LOAD, TX_ACK, TX_DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]    cnt, idx;
  logic [TW-1:0] timer;
  logic          rxrdy_q, rxerr_q;
  logic [W-1:0]  din, txbuf;
  logic          rx_byte, rx_fault, timeout, frame_ok;

  // Edge registers reset high so levels already asserted at reset are not events.
  assign rx_byte  = bus.uart_rxrdy & ~rxrdy_q;
  assign rx_fault = bus.uart_rxerr & ~rxerr_q;
  assign timeout  = (cnt != 5'd0) && !rx_byte && (timer == TW'(TIMEOUT_CYCLES - 1));
  assign busy     = !(state == RX && cnt == 5'd0);
  assign bus.core_din = din;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] rx_sum, tx_sum, res_sum;
  always_comb begin
    res_sum = 8'd0;
    for (int i = 0; i < FRAME_BYTES; i++) res_sum ^= bus.core_dout[8*i +: 8];
  end
  // Running XOR over payload plus checksum byte is zero for a good frame.
  assign frame_ok = (rx_sum == 8'd0);
  assign bus.uart_txdata = (idx == 5'(FRAME_BYTES)) ? tx_sum : txbuf[W-1 -: 8];
`else
  assign frame_ok = 1'b1;
  assign bus.uart_txdata = txbuf[W-1 -: 8];
`endif

  always_comb begin
    state_nxt        = state;
    bus.core_start   = 1'b0;
    bus.uart_txstart = 1'b0;
    case (state)
      RX:        if (!rx_fault && rx_byte && cnt == 5'(NBYTES - 1)) state_nxt = CHK;
      CHK:       state_nxt = frame_ok ? START : RX;
      START:     begin bus.core_start = 1'b1; state_nxt = WAIT_CORE; end
      WAIT_CORE: if (bus.core_done) state_nxt = TX_LOAD;
      TX_LOAD:   if (bus.uart_txrdy) begin bus.uart_txstart = 1'b1; state_nxt = TX_ACK; end
      TX_ACK:    if (!bus.uart_txrdy) state_nxt = TX_DONE;
      TX_DONE:   if (bus.uart_txrdy) state_nxt = (idx == 5'(NBYTES - 1)) ? RX : TX_LOAD;
      default:   state_nxt = RX;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (rstin) begin
      state   <= RX;
      cnt     <= 5'd0;
      idx     <= 5'd0;
      timer   <= '0;
      din     <= '0;
      txbuf   <= '0;
      err     <= 1'b0;
      rxrdy_q <= 1'b1;
      rxerr_q <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
      rx_sum  <= 8'd0;
      tx_sum  <= 8'd0;
`endif
    end else begin
      state   <= state_nxt;
      rxrdy_q <= bus.uart_rxrdy;
      rxerr_q <= bus.uart_rxerr;
      case (state)
        RX: begin
          if (rx_fault) begin
            err   <= 1'b1;
            cnt   <= 5'd0;
            timer <= '0;
          end else if (rx_byte) begin
            if (cnt < 5'(FRAME_BYTES)) din <= {din[W-9:0], bus.uart_rxdata};
`ifdef FRAME_CHECKSUM_EN
            rx_sum <= (cnt == 5'd0) ? bus.uart_rxdata : (rx_sum ^ bus.uart_rxdata);
`endif
            cnt   <= (cnt == 5'(NBYTES - 1)) ? 5'd0 : cnt + 5'd1;
            timer <= '0;
          end else if (timeout) begin
            cnt   <= 5'd0;
            timer <= '0;
          end else if (cnt != 5'd0) begin
            timer <= timer + TW'(1);
          end
        end
        CHK: if (!frame_ok) err <= 1'b1;
        WAIT_CORE: if (bus.core_done) begin
          txbuf <= bus.core_dout;
          idx   <= 5'd0;
`ifdef FRAME_CHECKSUM_EN
          tx_sum <= res_sum;
`endif
        end
        // Buffer shifts so the byte on the wire is always the top byte.
        TX_DONE: if (bus.uart_txrdy) begin
          idx   <= (idx == 5'(NBYTES - 1)) ? 5'd0 : idx + 5'd1;
          txbuf <= txbuf << 8;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: expected core frames and tx bytes are queued at stimulus time.
module tb_uart_frame_ctrl;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;
  int   checks = 0, fails = 0, n_core = 0, n_tx = 0;
  bit   tx_active = 1'b0;
  logic [127:0] exp_din[$];
  logic [7:0]   exp_tx[$];

  uart_frame_ctrl_if bus();

  uart_frame_ctrl #(.TIMEOUT_CYCLES(TO), .FRAME_BYTES(16)) dut (
    .clkin(clk), .rstin(rst), .bus(bus.master), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] xsum(input logic [127:0] v);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 16; i++) s ^= v[8*i +: 8];
    return s;
  endfunction

  // Core-side monitor: every core_start must match a queued frame.
  always @(negedge clk) begin
    if (bus.core_start === 1'b1) begin
      n_core++;
      if (exp_din.size() == 0) chk("core_unexpected", 1, 0);
      else chk("core_din", bus.core_din, exp_din.pop_front());
    end
  end

  // UART transmitter model with byte checking and data-hold checks.
  initial begin
    logic [7:0] d;
    bus.uart_txrdy = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.uart_txstart === 1'b1) begin
        tx_active = 1'b1;
        n_tx++;
        d = bus.uart_txdata;
        chk("tx_rdy_at_start", bus.uart_txrdy, 1);
        if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_data", d, exp_tx.pop_front());
        repeat (2) @(posedge clk);
        #1 chk("tx_hold_ack", bus.uart_txdata, d);
        bus.uart_txrdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("tx_hold_done", bus.uart_txdata, d);
        bus.uart_txrdy = 1'b1;
        tx_active = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.uart_rxrdy  = 1'b0;
    bus.uart_rxdata = b;
    repeat (2) @(posedge clk);
    #1 bus.uart_rxrdy = 1'b1;
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [127:0] d);
    exp_din.push_back(d);
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
`ifdef FRAME_CHECKSUM_EN
    send_byte(xsum(d));
`endif
  endtask

  task automatic wait_core(input int target);
    int n = 0;
    while (n_core < target && n < 200) begin @(negedge clk); n++; end
    chk("core_start_seen", n_core, target);
    chk("busy_wait_core", busy, 1);
  endtask

  task automatic core_respond(input logic [127:0] r);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) exp_tx.push_back(r[127-8*i -: 8]);
`ifdef FRAME_CHECKSUM_EN
    exp_tx.push_back(xsum(r));
`endif
    bus.core_dout = r;
    bus.core_done = 1'b1;
    @(posedge clk); #1;
    bus.core_done = 1'b0;
    bus.core_dout = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_tx();
    int n = 0;
    while ((exp_tx.size() != 0 || tx_active) && n < 3000) begin @(negedge clk); n++; end
    chk("tx_drained", exp_tx.size(), 0);
    repeat (3) @(posedge clk);
    #1 chk("busy_after_tx", busy, 0);
  endtask

  task automatic full_frame(input logic [127:0] d, input logic [127:0] r);
    int base = n_core;
    send_frame(d);
    wait_core(base + 1);
    core_respond(r);
    wait_tx();
  endtask

  initial begin
    logic [127:0] d;
    int base, n;
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d, r;
    int base, n;
    bus.uart_rxdata = 8'd0;
    bus.uart_rxrdy  = 1'b1;
    bus.uart_rxerr  = 1'b0;
    bus.core_done   = 1'b0;
    bus.core_dout   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_core_din", bus.core_din, 0);
    chk("rst_txdata", bus.uart_txdata, 0);
    chk("rst_txstart", bus.uart_txstart, 0);
    chk("rst_core_start", bus.core_start, 0);
    rst = 1'b0;

    // rxrdy high across reset release is not a byte
    repeat (5) @(posedge clk);
    #1 chk("rdy_high_no_byte", busy, 0);

    // stray core_done while idle must not start transmission
    bus.core_dout = {4{32'hDEADBEEF}};
    bus.core_done = 1'b1;
    @(posedge clk); #1 bus.core_done = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("stray_done_idle", busy, 0);

    full_frame(128'h000102030405060708090A0B0C0D0E0F, {16{8'hA5}});
    full_frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

    // inter-byte timeout drops a partial frame silently
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    #1 chk("partial_busy", busy, 1);
    repeat (TO + 5) @(posedge clk);
    #1 chk("timeout_busy", busy, 0);
    chk("timeout_err", err, 0);
    full_frame(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 128'h0123456789ABCDEFFEDCBA9876543210);

    // rx error mid-frame
    base = n_core;
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    #1 bus.uart_rxerr = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rxerr_err", err, 1);
    chk("rxerr_cnt_clear", busy, 0);
    for (int i = 5; i < 16; i++) send_byte(8'(i));
    repeat (5) @(posedge clk);
    #1 chk("rxerr_no_core", n_core, base);
    chk("rxerr_err_sticky", err, 1);
    bus.uart_rxerr = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_clears_err", err, 0);

    // reset in the middle of transmission abandons the frame
    base = n_core;
    send_frame(128'h11223344556677889900AABBCCDDEEFF);
    wait_core(base + 1);
    core_respond({16{8'h3C}});
    n = 0;
    while (!(exp_tx.size() <= 12 && !tx_active) && n < 2000) begin @(negedge clk); n++; end
    chk("mid_tx_reached", exp_tx.size() <= 12, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_tx.delete();
    chk("mid_tx_rst_busy", busy, 0);
    chk("mid_tx_rst_txdata", bus.uart_txdata, 0);
    repeat (30) @(posedge clk);
    full_frame({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});

`ifdef FRAME_CHECKSUM_EN
    // bad checksum: err set, no core start, back to idle RX
    base = n_core;
    d = 128'h000102030405060708090A0B0C0D0E0F;
    for (int i = 0; i < 16; i++) send_byte(d[127-8*i -: 8]);
    send_byte(8'hFF);
    repeat (5) @(posedge clk);
    #1 chk("bad_csum_err", err, 1);
    chk("bad_csum_no_core", n_core, base);
    chk("bad_csum_idle", busy, 0);
`endif

    chk("sb_din_empty", exp_din.size(), 0);
    chk("sb_tx_empty", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_frame_ctrl.md
UART_FRAME_CTRL -- requirements
Module: uart_frame_ctrl

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 1000000, inter-byte timeout in clkin cycles; FRAME_BYTES, fixed at 16, payload bytes per frame.
REQ-002 clkin  input  1  system clock; all logic SHALL be on its rising edge.
REQ-003 rstin  input  1  reset; synchronous, active-high.
REQ-004 uart_rxdata  input  8  received byte from the UART.
REQ-005 uart_rxrdy  input  1  UART receive-ready level; stays high until the next start bit.
REQ-006 uart_rxerr  input  1  UART stop-bit error level; sticky until UART reset.
REQ-007 uart_txrdy  input  1  UART transmitter idle.
REQ-008 uart_txstart  output  1  one-cycle transmit request to the UART.
REQ-009 uart_txdata  output  8  byte to transmit.
REQ-010 core_din  output  128  assembled frame for the crypto core.
REQ-011 core_start  output  1  one-cycle core start pulse.
REQ-012 core_done  input  1  core result-valid pulse.
REQ-013 core_dout  input  128  core result.
REQ-014 busy  output  1  high in every state except RX with zero bytes collected.
REQ-015 err  output  1  sticky frame error.

Function
REQ-016 States SHALL be RX, CHK, START, WAIT_CORE, TX_LOAD, TX_ACK and TX_DONE.
REQ-017 A byte SHALL be accepted only on a 0->1 edge of uart_rxrdy; the edge register resets to 1, so a level still high after reset is not a byte.
REQ-018 RX SHALL shift bytes into core_din, first byte into [127:120]; on the last payload byte the state SHALL go to CHK.
REQ-019 Rx byte edges outside RX SHALL be discarded.
REQ-020 A uart_rxerr 0->1 edge in RX SHALL set err, clear the byte count and stay in RX; its edge register also resets to 1.
REQ-021 In RX with byte count >0, a cycle counter SHALL run; reaching TIMEOUT_CYCLES-1 with no new byte SHALL clear the count silently (err unchanged).
REQ-022 CHK SHALL go to START in one cycle when the frame is valid (see Configuration).
REQ-023 START SHALL assert core_start for exactly one cycle, then go to WAIT_CORE.
REQ-024 core_din SHALL be held stable from CHK until the next frame's first byte.
REQ-025 WAIT_CORE SHALL latch core_dout into a 128-bit TX buffer on the cycle core_done=1, then go to TX_LOAD.
REQ-026 core_done outside WAIT_CORE SHALL be ignored.
REQ-027 No timeout SHALL apply in WAIT_CORE.
REQ-028 TX_LOAD SHALL wait for uart_txrdy=1, then drive uart_txdata and pulse uart_txstart for one cycle, then go to TX_ACK.
REQ-029 TX_ACK SHALL wait for uart_txrdy=0, then go to TX_DONE.
REQ-030 TX_DONE SHALL wait for uart_txrdy=1, then advance the byte index.
REQ-031 After TX_DONE, the state SHALL return to TX_LOAD if bytes remain, else to RX with count 0.
REQ-032 Bytes SHALL be sent MSB byte first ([127:120]).
REQ-033 uart_txdata SHALL stay constant from the txstart cycle until TX_DONE exits.
REQ-034 Byte counter and index SHALL be 5 bits, with no wrap beyond the frame length.

Reset
REQ-035 rstin=1 SHALL, on the next clkin edge, force state RX, counters 0, core_din 0, TX buffer 0, uart_txdata 0, uart_txstart 0, core_start 0, busy 0, err 0, and both edge registers to 1.
REQ-036 Reset mid-transmission SHALL abandon the frame; the first post-reset TX_LOAD still waits for uart_txrdy=1.

Configuration
REQ-037 With FRAME_CHECKSUM_EN defined, RX SHALL collect 17 bytes; byte 17 is the XOR of the 16 payload bytes and is not stored in core_din.
REQ-038 With FRAME_CHECKSUM_EN defined, on a checksum mismatch CHK SHALL set err and return to RX without core_start.
REQ-039 With FRAME_CHECKSUM_EN defined, TX SHALL append a 17th byte: the XOR of the 16 result bytes.
REQ-040 Without FRAME_CHECKSUM_EN, frames SHALL be 16 bytes each way, CHK SHALL always pass, and no checksum logic SHALL be present.

Verification
REQ-041 Send bytes 0x00..0x0F (plus checksum 0x00 if enabled) -> one core_start pulse with core_din=0x000102...0F.
REQ-042 Core returns 0xA5A5...A5 -> 16 uart_txstart pulses, each only after uart_txrdy re-rises, each with uart_txdata=0xA5 (plus 0x00 checksum if enabled).
REQ-043 Send 5 bytes, then idle TIMEOUT_CYCLES -> count cleared, err=0; next 16 bytes form a fresh frame.
REQ-044 Assert uart_rxerr mid-frame -> err=1, no core_start; release rstin -> err=0.
REQ-045 uart_rxrdy already high at reset release -> no byte accepted until it falls and rises.
REQ-046 FRAME_CHECKSUM_EN with bad checksum 0xFF for payload 0x00.. -> err=1, no core_start, state RX.
